fpu_scheduler: RTL and testbench

Shares one multi-cycle FPU core between two requesters (integer pipe, vector pipe).
- Arbitrates round-robin and latches the winning operands and command.
- Issues a start pulse to the core and waits for its done.
- Returns the result, tagged with the requester id, on a valid/ready response channel.
- A watchdog aborts operations the core never completes.

---
 rtl/fpu_pkg.sv | 43 ++++
 rtl/fpu_rr_arbiter.sv | 20 ++
 rtl/fpu_scheduler.sv | 142 ++++++++++++++
 tb/tb_fpu_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU scheduler definitions: opcodes, FSM states and format helpers.
package fpu_pkg;

    localparam logic [2:0] FPU_ADD = 3'd0;
    localparam logic [2:0] FPU_SUB = 3'd1;
    localparam logic [2:0] FPU_MUL = 3'd2;
    localparam logic [2:0] FPU_DIV = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } fpu_state_t;

    function automatic int fpu_exp_width(input int bitness);
        case (bitness)
            16:      return 5;
            32:      return 8;
            64:      return 11;
            128:     return 15;
            256:     return 19;
            default: return 0;
        endcase
    endfunction

    function automatic int fpu_man_width(input int bitness);
        case (bitness)
            16:      return 11;
            32:      return 24;
            64:      return 53;
            128:     return 113;
            256:     return 237;
            default: return 0;
        endcase
    endfunction

    // Only the four basic arithmetic opcodes reach the core.
    function automatic logic fpu_op_legal(input logic [31:0] cmd);
        return cmd <= 32'(FPU_DIV);
    endfunction

endpackage

// File: rtl/fpu_rr_arbiter.sv
// Two-way round-robin arbiter: a tie goes to the requester not granted last.
module fpu_rr_arbiter (
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

    always_comb begin
        grant_valid = |valid;
        grant_id    = 1'b0;
        unique case (valid)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/fpu_scheduler.sv
// Shares one multi-cycle FPU core between two requesters with a
// round-robin grant, a watchdog and a tagged valid/ready response.
module fpu_scheduler
    import fpu_pkg::*;
#(
    parameter int BITNESS      = 64,
    parameter int COMMAND_SIZE = 3,
    parameter int TIMEOUT      = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req0_valid,
    output logic                    req0_ready,
    input  logic [BITNESS-1:0]      req0_first,
    input  logic [BITNESS-1:0]      req0_second,
    input  logic [COMMAND_SIZE-1:0] req0_command,
    input  logic                    req1_valid,
    output logic                    req1_ready,
    input  logic [BITNESS-1:0]      req1_first,
    input  logic [BITNESS-1:0]      req1_second,
    input  logic [COMMAND_SIZE-1:0] req1_command,
    output logic                    fpu_start,
    output logic [BITNESS-1:0]      fpu_first,
    output logic [BITNESS-1:0]      fpu_second,
    output logic [COMMAND_SIZE-1:0] fpu_command,
    input  logic                    fpu_done,
    input  logic [BITNESS-1:0]      fpu_result,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_id,
    output logic [BITNESS-1:0]      rsp_result,
    output logic                    rsp_error
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    fpu_state_t state, state_next;

    logic                    last_grant;
    logic [CW-1:0]           tmo_cnt;
    logic                    grant_valid;
    logic                    grant_id;
    logic [BITNESS-1:0]      win_first;
    logic [BITNESS-1:0]      win_second;
    logic [COMMAND_SIZE-1:0] win_command;
    logic                    win_legal;
    logic                    timeout_hit;

    fpu_rr_arbiter u_arb (
        .valid       ({req1_valid, req0_valid}),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        win_first   = grant_id ? req1_first   : req0_first;
        win_second  = grant_id ? req1_second  : req0_second;
        win_command = grant_id ? req1_command : req0_command;
        win_legal   = fpu_op_legal(32'(win_command));
        timeout_hit = (tmo_cnt == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        fpu_start  = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    req0_ready = ~grant_id;
                    req1_ready = grant_id;
                    state_next = win_legal ? ST_ISSUE : ST_RESP;
                end
            end
            ST_ISSUE: begin
                fpu_start  = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (fpu_done || timeout_hit) state_next = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operand latches double as the core inputs; they only move on a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant  <= 1'b1;
            tmo_cnt     <= '0;
            fpu_first   <= '0;
            fpu_second  <= '0;
            fpu_command <= '0;
            rsp_id      <= 1'b0;
            rsp_result  <= '0;
            rsp_error   <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (grant_valid) begin
                        fpu_first   <= win_first;
                        fpu_second  <= win_second;
                        fpu_command <= win_command;
                        rsp_id      <= grant_id;
                        if (!win_legal) begin
                            rsp_result <= '0;
                            rsp_error  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: tmo_cnt <= '0;
                ST_WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (fpu_done) begin
                        rsp_result <= fpu_result;
                        rsp_error  <= 1'b0;
                    end else if (timeout_hit) begin
                        rsp_result <= '0;
                        rsp_error  <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) last_grant <= rsp_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_scheduler.sv
// Directed scoreboard bench for fpu_scheduler with a behavioural core model.
module tb_fpu_scheduler;

    localparam int W  = 64;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [W-1:0]  req0_first = '0, req0_second = '0;
    logic [W-1:0]  req1_first = '0, req1_second = '0;
    logic [2:0]    req0_command = '0, req1_command = '0;
    logic          fpu_start;
    logic [W-1:0]  fpu_first, fpu_second;
    logic [2:0]    fpu_command;
    logic          fpu_done = 1'b0;
    logic [W-1:0]  fpu_result = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_id;
    logic [W-1:0]  rsp_result;
    logic          rsp_error;

    fpu_scheduler #(.BITNESS(W), .COMMAND_SIZE(3), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_first   (req0_first),
        .req0_second  (req0_second),
        .req0_command (req0_command),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_first   (req1_first),
        .req1_second  (req1_second),
        .req1_command (req1_command),
        .fpu_start    (fpu_start),
        .fpu_first    (fpu_first),
        .fpu_second   (fpu_second),
        .fpu_command  (fpu_command),
        .fpu_done     (fpu_done),
        .fpu_result   (fpu_result),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_result   (rsp_result),
        .rsp_error    (rsp_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         id;
        logic [W-1:0] result;
        logic         err;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   n_start = 0;

    // Core model: done comes k cycles after the edge that captures start.
    int           core_delay = 3;
    bit           core_on = 1'b1;
    bit           inject_done = 1'b0;
    bit           override_en = 1'b0;
    logic [W-1:0] override_val = '0;
    int           core_cnt = 0;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (fpu_start) n_start++;

    always @(negedge clk) begin
        fpu_done = 1'b0;
        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) fpu_done = 1'b1;
        end
        if (inject_done) fpu_done = 1'b1;
        if (fpu_start && core_on) begin
            core_cnt = core_delay + 1;
            fpu_result = override_en ? override_val
                       : fpu_first + fpu_second + W'(fpu_command);
        end
    end

    task automatic check(input string tag, input logic [W-1:0] obs,
                         input logic [W-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always begin
        @(negedge clk);
        #4;
        if (!rst && rsp_valid && rsp_ready) begin
            if (q.size() == 0) begin
                check("sb_unexpected_rsp", W'(q.size()), 1);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rsp_id", W'(rsp_id), W'(e.id));
                check("rsp_result", rsp_result, e.result);
                check("rsp_error", W'(rsp_error), W'(e.err));
            end
        end
    end

    task automatic push(input logic id, input logic [W-1:0] r, input logic e);
        exp_t x;
        x.id = id;
        x.result = r;
        x.err = e;
        q.push_back(x);
    endtask

    task automatic request(input logic id, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [2:0] cmd,
                           output int g);
        @(negedge clk);
        if (id) begin
            req1_valid = 1'b1; req1_first = a;
            req1_second = b; req1_command = cmd;
        end else begin
            req0_valid = 1'b1; req0_first = a;
            req0_second = b; req0_command = cmd;
        end
        g = -1;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (id ? req1_ready : req0_ready) begin
                g = cyc;
                check("grant_other_ready", W'(id ? req0_ready : req1_ready), 0);
                break;
            end
            @(negedge clk);
        end
        check("grant_seen", W'(g >= 0), 1);
        @(negedge clk);
        if (id) req1_valid = 1'b0;
        else    req0_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int g, output int lat);
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            #1;
            if (rsp_valid) begin
                lat = cyc - g;
                break;
            end
            @(negedge clk);
        end
        check("rsp_seen", W'(lat >= 0), 1);
    endtask

    initial begin
        int g, lat, s0, bad, nb;
        logic         h_id, h_err;
        logic [W-1:0] h_res;
        int           order[4];

        repeat (3) @(negedge clk);
        #1;
        check("reset_ctrl", W'({fpu_start, rsp_valid, rsp_error, rsp_id,
                                req0_ready, req1_ready}), 0);
        check("reset_fpu_first", fpu_first, 0);
        check("reset_rsp_result", rsp_result, 0);
        rst = 1'b0;
        rsp_ready = 1'b1;

        // Single legal op with latency checks
        core_delay = 3;
        override_en = 1'b1;
        override_val = 64'h4008000000000000;
        push(1'b0, 64'h4008000000000000, 1'b0);
        request(1'b0, 64'h3FF0000000000000, 64'h4000000000000000, 3'd0, g);
        #1;
        check("start_after_grant", W'(fpu_start), 1);
        check("start_cycle", W'(cyc - g), 1);
        wait_rsp(g, lat);
        check("single_latency", W'(lat), 6);
        override_en = 1'b0;

        // Illegal opcode from requester 1
        s0 = n_start;
        push(1'b1, '0, 1'b1);
        request(1'b1, 64'h11, 64'h22, 3'd5, g);
        wait_rsp(g, lat);
        check("illegal_latency", W'(lat), 1);
        @(negedge clk);
        #1;
        check("illegal_no_start", W'(n_start - s0), 0);

        // Contention: both valid continuously
        core_delay = 2;
        s0 = n_start;
        push(1'b0, 64'd30, 1'b0);
        push(1'b1, 64'd106, 1'b0);
        push(1'b0, 64'd30, 1'b0);
        push(1'b1, 64'd106, 1'b0);
        @(negedge clk);
        req0_first = 64'd10;  req0_second = 64'd20; req0_command = 3'd0;
        req1_first = 64'd100; req1_second = 64'd5;  req1_command = 3'd1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        nb = 0;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (req0_ready && req1_ready) bad++;
            if (req0_ready || req1_ready) begin
                order[nb] = int'(req1_ready);
                nb++;
                if (nb == 4) break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        check("rr_grant_count", W'(nb), 4);
        for (int i = 0; i < 4; i++) check("rr_order", W'(order[i]), W'(i % 2));
        check("rr_two_readys", W'(bad), 0);
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check("rr_drained", W'(q.size()), 0);
        check("rr_start_count", W'(n_start - s0), 4);

        // Watchdog timeout, then a late done and a normal op
        #1 core_on = 1'b0;
        push(1'b0, '0, 1'b1);
        request(1'b0, 64'h5, 64'h6, 3'd2, g);
        wait_rsp(g, lat);
        check("timeout_latency", W'(lat), TO + 2);
        @(negedge clk);
        #1 inject_done = 1'b1;
        @(negedge clk);
        #1 inject_done = 1'b0;
        check("late_done_no_rsp", W'(rsp_valid), 0);
        @(negedge clk);
        #1;
        check("late_done_no_start", W'({fpu_start, rsp_valid}), 0);
        core_on = 1'b1;
        push(1'b1, 64'd17, 1'b0);
        request(1'b1, 64'd7, 64'd8, 3'd2, g);
        wait_rsp(g, lat);
        check("after_timeout_latency", W'(lat), 5);

        // Backpressure on the response channel
        @(negedge clk);
        rsp_ready = 1'b0;
        push(1'b0, 64'h1237, 1'b0);
        request(1'b0, 64'h1000, 64'h0234, 3'd3, g);
        wait_rsp(g, lat);
        h_id = rsp_id;
        h_res = rsp_result;
        h_err = rsp_error;
        req1_first = 64'd1; req1_second = 64'd2; req1_command = 3'd0;
        req1_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (!rsp_valid || rsp_id !== h_id || rsp_result !== h_res ||
                rsp_error !== h_err || req0_ready || req1_ready) bad++;
        end
        check("bp_stable", W'(bad), 0);
        push(1'b1, 64'd3, 1'b0);
        @(negedge clk);
        rsp_ready = 1'b1;
        #1;
        check("bp_no_grant_on_hs", W'(req1_ready), 0);
        @(negedge clk);
        #1;
        check("bp_valid_drop", W'(rsp_valid), 0);
        check("bp_idle_grant", W'(req1_ready), 1);
        g = cyc;
        @(negedge clk);
        req1_valid = 1'b0;
        wait_rsp(g, lat);
        check("bp_next_latency", W'(lat), 5);

        // Asynchronous reset while waiting on the core
        @(negedge clk);
        #1 core_delay = 20;
        request(1'b0, 64'h9, 64'h9, 3'd0, g);
        repeat (3) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("rst_mid_ctrl", W'({fpu_start, rsp_valid, rsp_error, rsp_id,
                                  req0_ready, req1_ready}), 0);
        check("rst_mid_first", fpu_first, 0);
        check("rst_mid_cmd", W'(fpu_command), 0);
        check("rst_mid_result", rsp_result, 0);
        @(negedge clk);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            #1;
            if (rsp_valid || fpu_start) bad++;
        end
        check("rst_stale_done_ignored", W'(bad), 0);
        core_delay = 1;
        push(1'b0, 64'h100, 1'b0);
        request(1'b0, 64'h55, 64'hAA, 3'd1, g);
        wait_rsp(g, lat);
        check("post_rst_latency", W'(lat), 4);

        repeat (3) @(negedge clk);
        check("sb_empty", W'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
